// File: rtl/serial_parity_deserializer.sv
// Serial-to-parallel receiver for an LSB-first bit stream that carries one
// trailing XOR parity bit per word. It checks parity on each frame. It
// discards partial frames on a restart or on an inactivity timeout and
// reports each discard with a one-cycle frame_abort pulse.
module serial_parity_deserializer #(
    parameter int WIDTH      = 8,
    parameter bit ODD_PARITY = 1'b0,
    parameter int MAX_GAP    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic             up_start,
    input  logic             up_bit,
    output logic             down_valid,
    output logic [WIDTH-1:0] down_data,
    output logic             down_parity_err,
    output logic             frame_abort,
    output logic             busy
);

    // Counter wide enough to hold WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LAST = 8'(MAX_GAP - 1);

    // Reject parameter values outside the supported ranges at elaboration time.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_parity_deserializer: WIDTH must be 2..32");
    end
    if (MAX_GAP < 1 || MAX_GAP > 255) begin : g_bad_gap
        $error("serial_parity_deserializer: MAX_GAP must be 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    // Parity is bad when the XOR of all received bits differs from the target.
    function automatic logic parity_mismatch(input logic acc, input logic odd);
        return acc != odd;
    endfunction

    // Returns word with bit position idx replaced by b.
    function automatic logic [WIDTH-1:0] place_bit(input logic [WIDTH-1:0] word,
                                                   input logic [CW-1:0]    idx,
                                                   input logic             b);
        logic [WIDTH-1:0] w;
        w = word;
        for (int i = 0; i < WIDTH; i++) begin
            w[i] = (idx == CW'(i)) ? b : w[i];
        end
        return w;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic             acc_q, acc_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             dv_q, dv_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             start_s;
    logic             bit_s;

    // Next-state logic: frame assembly, parity check, restart and timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        acc_d   = acc_q;
        word_d  = word_q;
        dv_d    = 1'b0;
        data_d  = data_q;
        err_d   = 1'b0;
        abort_d = 1'b0;
        start_s = up_valid && up_start;
        bit_s   = up_valid && !up_start;

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_DATA;
                    word_d  = place_bit({WIDTH{1'b0}}, {CW{1'b0}}, up_bit);
                    acc_d   = up_bit;
                    cnt_d   = CW'(1);
                    gap_d   = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA, S_PARITY: begin
                if (start_s) begin
                    // A restart discards the current frame. The start bit
                    // becomes bit 0 of the new frame in the same cycle.
                    abort_d = 1'b1;
                    state_d = S_DATA;
                    word_d  = place_bit({WIDTH{1'b0}}, {CW{1'b0}}, up_bit);
                    acc_d   = up_bit;
                    cnt_d   = CW'(1);
                    gap_d   = 8'd0;
                end else if (bit_s) begin
                    gap_d = 8'd0;
                    if (state_q == S_DATA) begin
                        word_d = place_bit(word_q, cnt_q, up_bit);
                        acc_d  = acc_q ^ up_bit;
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        dv_d    = 1'b1;
                        data_d  = word_q;
                        err_d   = parity_mismatch(acc_q ^ up_bit, ODD_PARITY);
                        state_d = S_IDLE;
                        cnt_d   = {CW{1'b0}};
                        acc_d   = 1'b0;
                    end
                end else if (gap_q == GAP_LAST) begin
                    // Last allowed idle cycle has passed: drop the frame.
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                    gap_d   = 8'd0;
                    cnt_d   = {CW{1'b0}};
                    acc_d   = 1'b0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
                gap_d   = 8'd0;
                acc_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            gap_q   <= 8'd0;
            acc_q   <= 1'b0;
            word_q  <= {WIDTH{1'b0}};
            dv_q    <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            dv_q    <= dv_d;
            data_q  <= data_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
        end
    end

    assign down_valid      = dv_q;
    assign down_data       = data_q;
    assign down_parity_err = err_q;
    assign frame_abort     = abort_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_serial_parity_deserializer.sv
// Testbench for serial_parity_deserializer. An even-parity instance and an
// odd-parity instance share one randomized bit stream. A bit-list reference
// model queues the expected frame and abort events, and a monitor matches the
// events both instances present.
module tb_serial_parity_deserializer;

    localparam int W  = 8;
    localparam int MG = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_valid = 1'b0;
    logic       up_start = 1'b0;
    logic       up_bit = 1'b0;
    logic       dv0, err0, ab0, busy0;
    logic [7:0] data0;
    logic       dv1, err1, ab1, busy1;
    logic [7:0] data1;

    serial_parity_deserializer #(.WIDTH(W), .ODD_PARITY(1'b0), .MAX_GAP(MG)) dut_even (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_start(up_start), .up_bit(up_bit),
        .down_valid(dv0), .down_data(data0), .down_parity_err(err0),
        .frame_abort(ab0), .busy(busy0));

    serial_parity_deserializer #(.WIDTH(W), .ODD_PARITY(1'b1), .MAX_GAP(MG)) dut_odd (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_start(up_start), .up_bit(up_bit),
        .down_valid(dv1), .down_data(data1), .down_parity_err(err1),
        .frame_abort(ab1), .busy(busy1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_frame;
        int         at;
        logic [7:0] data;
        bit         err_e;
        bit         err_o;
    } exp_t;
    exp_t expq[$];

    // Reference model: the list of bits received for the open frame.
    bit mbits[$];
    bit m_in  = 1'b0;
    int m_gap = 0;

    // Monitor statistics for the directed checks.
    int         dv_cnt = 0;
    int         ab_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_err0 = 1'b0;
    logic       last_err1 = 1'b0;
    int         last_dv_cyc = 0;
    int         prev_dv_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_abort(input int at);
        exp_t e;
        e.is_frame = 1'b0; e.at = at; e.data = 8'h00; e.err_e = 1'b0; e.err_o = 1'b0;
        expq.push_back(e);
    endtask

    // Applies the protocol rules to one input cycle whose result appears at cycle 'at'.
    task automatic model_step(input bit v, input bit s, input bit b, input int at);
        exp_t e;
        bit   x;
        if (v && s) begin
            if (m_in) push_abort(at);
            mbits.delete();
            mbits.push_back(b);
            m_in  = 1'b1;
            m_gap = 0;
        end else if (v && m_in) begin
            mbits.push_back(b);
            m_gap = 0;
            if (mbits.size() == W + 1) begin
                x = 1'b0;
                e.data = 8'h00;
                for (int i = 0; i < W; i++) e.data[i] = mbits[i];
                foreach (mbits[i]) x ^= mbits[i];
                e.is_frame = 1'b1;
                e.at       = at;
                e.err_e    = (x != 1'b0);
                e.err_o    = (x != 1'b1);
                expq.push_back(e);
                m_in = 1'b0;
                mbits.delete();
            end
        end else if (!v && m_in) begin
            m_gap++;
            if (m_gap == MG) begin
                push_abort(at);
                m_in = 1'b0;
                mbits.delete();
            end
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit b);
        @(posedge clk);
        #1;
        up_valid = v;
        up_start = s;
        up_bit   = b;
        model_step(v, s, b, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input int gapmax);
        drive(1'b1, 1'b1, d[0]);
        for (int i = 1; i < W; i++) begin
            idle($urandom_range(0, gapmax));
            drive(1'b1, 1'b0, d[i]);
        end
        idle($urandom_range(0, gapmax));
        drive(1'b1, 1'b0, par);
    endtask

    // Start bit plus n-1 further data bits from d, leaving the frame open.
    task automatic send_partial(input logic [7:0] d, input int n);
        drive(1'b1, 1'b1, d[0]);
        for (int i = 1; i < n; i++) drive(1'b1, 1'b0, d[i]);
    endtask

    // One reset cycle; leaves control at the start of the cycle after the reset edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        up_valid = 1'b0;
        up_start = 1'b0;
        up_bit   = 1'b0;
        m_in     = 1'b0;
        m_gap    = 0;
        mbits.delete();
        while (expq.size() > 0 && expq[expq.size()-1].at >= cyc) void'(expq.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: matches every presented event against the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("exclusive_pulses", {30'd0, dv0 & ab0, dv1 & ab1}, 32'd0);
            if (!dv0 || !dv1) check("err_low_without_valid", {30'd0, err0 & !dv0, err1 & !dv1}, 32'd0);
            if (dv0 || ab0 || dv1 || ab1) begin
                if (expq.size() == 0) begin
                    check("unexpected_event", {28'd0, dv0, ab0, dv1, ab1}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("event_cycle", cyc, e.at);
                    check("valid_even", dv0, e.is_frame);
                    check("abort_even", ab0, !e.is_frame);
                    check("valid_odd", dv1, e.is_frame);
                    check("abort_odd", ab1, !e.is_frame);
                    if (e.is_frame) begin
                        check("data_even", data0, e.data);
                        check("data_odd", data1, e.data);
                        check("perr_even", err0, e.err_e);
                        check("perr_odd", err1, e.err_o);
                    end
                end
                if (dv0) begin
                    dv_cnt++;
                    last_data   = data0;
                    last_err0   = err0;
                    last_err1   = err1;
                    prev_dv_cyc = last_dv_cyc;
                    last_dv_cyc = cyc;
                end
                if (ab0) ab_cnt++;
            end else if (expq.size() > 0 && expq[0].at <= cyc) begin
                e = expq.pop_front();
                check("missed_event_at", cyc, e.at);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0;
        logic [7:0] rd;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {10'd0, dv0, data0, err0, ab0, busy0, dv1, data1, err1, ab1, busy1}, 32'd0);
        rst = 1'b0;

        // Even parity: 0xA5 with correct and wrong parity, then 0x07.
        send_frame(8'hA5, 1'b0, 0); idle(2);
        check("a5_data", last_data, 8'hA5);
        check("a5_p0_err_even", last_err0, 1'b0);
        check("a5_p0_err_odd", last_err1, 1'b1);
        send_frame(8'hA5, 1'b1, 0); idle(2);
        check("a5_p1_err_even", last_err0, 1'b1);
        send_frame(8'h07, 1'b1, 0); idle(2);
        check("07_p1_err_even", last_err0, 1'b0);

        // Odd parity: 0x00 with parity 1 then 0.
        send_frame(8'h00, 1'b1, 0); idle(2);
        check("00_p1_err_odd", last_err1, 1'b0);
        send_frame(8'h00, 1'b0, 0); idle(2);
        check("00_p0_err_odd", last_err1, 1'b1);

        // Restart after three data bits.
        d0 = dv_cnt; a0 = ab_cnt;
        send_partial(8'h05, 3);
        send_frame(8'h01, 1'b1, 0); idle(2);
        check("restart_abort_count", ab_cnt - a0, 1);
        check("restart_valid_count", dv_cnt - d0, 1);
        check("restart_data", last_data, 8'h01);
        check("restart_err", last_err0, 1'b0);

        // Gap timeout after four data bits.
        a0 = ab_cnt;
        send_partial(8'h0F, 4);
        idle(MG);
        check("busy_on_last_idle", busy0, 1'b1);
        idle(1);
        check("busy_after_timeout", busy0, 1'b0);
        idle(1);
        check("timeout_abort_count", ab_cnt - a0, 1);

        // A gap of MG-1 is tolerated.
        d0 = dv_cnt; a0 = ab_cnt;
        rd = 8'h3C;
        send_partial(rd, 4);
        idle(MG - 1);
        for (int i = 4; i < W; i++) drive(1'b1, 1'b0, rd[i]);
        drive(1'b1, 1'b0, 1'b0);
        idle(2);
        check("gap15_valid_count", dv_cnt - d0, 1);
        check("gap15_abort_count", ab_cnt - a0, 0);
        check("gap15_data", last_data, 8'h3C);

        // Reset in the middle of a frame is silent.
        a0 = ab_cnt;
        send_partial(8'h1F, 5);
        do_reset();
        check("midreset_outputs", {12'd0, dv0, data0, err0, ab0, busy0, dv1, err1, ab1, busy1}, 32'd0);
        idle(MG + 2);
        check("midreset_no_abort", ab_cnt - a0, 0);

        // Back-to-back frames.
        send_frame(8'h5A, 1'b0, 0);
        send_frame(8'hC3, 1'b1, 0);
        idle(2);
        check("b2b_spacing", last_dv_cyc - prev_dv_cyc, 9);

        // Randomized mix of frames, restarts, gaps, noise and resets.
        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r <= 4) begin
                send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? MG - 1 : 2);
            end else if (r <= 6) begin
                send_partial(8'($urandom), $urandom_range(1, W));
            end else if (r <= 8) begin
                idle($urandom_range(1, MG + 4));
            end else if (r <= 10) begin
                for (int k = 0; k < $urandom_range(1, 4); k++) drive(1'b1, 1'b0, 1'($urandom));
            end else begin
                do_reset();
            end
        end

        idle(MG + 4);
        check("scoreboard_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
